// File: rtl/encoder_input_conditioner.sv
// ============================================================================
// Module      : encoder_input_conditioner
// Description : Synchronises and debounces rotary-encoder A/B/switch pins and
//               produces A-rising and switch-press pulses for the digit FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_input_conditioner #(
  parameter int DEBOUNCE_LIMIT = 100000,
  parameter int SWITCH_LIMIT   = 500000
) (
  input  logic i_Clk,
  input  logic i_Reset_n,
  input  logic i_Encoder_A,
  input  logic i_Encoder_B,
  input  logic i_Encoder_Switch,
  output logic o_Encoder_A_Pulse,
  output logic o_Encoder_B_Debounced,
  output logic o_Encoder_Change_Mode,
  output logic o_Encoder_Switch_Held
);

  localparam int MAX_LIMIT = (DEBOUNCE_LIMIT > SWITCH_LIMIT) ? DEBOUNCE_LIMIT : SWITCH_LIMIT;
  localparam int SETTLE    = MAX_LIMIT + 4;
  // Sized to hold SETTLE itself, so the saturating counter can never wrap.
  localparam int CNT_W     = $clog2(SETTLE + 1);

  localparam logic [CNT_W-1:0] C_AB_LAST   = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] C_SW_LAST   = CNT_W'(SWITCH_LIMIT - 1);
  localparam logic [CNT_W-1:0] C_SETTLE    = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam int               C_PIN_A     = 0;
  localparam int               C_PIN_B     = 1;
  localparam int               C_PIN_SW    = 2;

  logic [2:0]       w_raw;
  logic [2:0]       s1_q, s1_d;
  logic [2:0]       s2_q, s2_d;
  logic [2:0]       stable_q, stable_d;
  logic [2:0]       stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [CNT_W-1:0] settle_q, settle_d;
  logic             w_settled;
  logic             a_pulse_q, a_pulse_d;
  logic             b_deb_q, b_deb_d;
  logic             change_mode_q, change_mode_d;
  logic             sw_held_q, sw_held_d;

  assign w_raw     = {i_Encoder_Switch, i_Encoder_B, i_Encoder_A};
  assign w_settled = (settle_q == C_SETTLE);

  always_comb begin
    s1_d         = w_raw;
    s2_d         = s1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == ((i == C_PIN_SW) ? C_SW_LAST : C_AB_LAST)) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + C_CNT_ONE;
      end
    end

    settle_d = w_settled ? settle_q : (settle_q + C_CNT_ONE);

    // Rotation is ignored while the switch is held; pulses wait for settle.
    a_pulse_d     = stable_q[C_PIN_A] & ~stable_dly_q[C_PIN_A] & ~stable_q[C_PIN_SW] & w_settled;
    b_deb_d       = stable_q[C_PIN_B];
    change_mode_d = stable_q[C_PIN_SW] & ~stable_dly_q[C_PIN_SW] & w_settled;
    sw_held_d     = stable_q[C_PIN_SW];
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      stable_q      <= '0;
      stable_dly_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      settle_q      <= '0;
      a_pulse_q     <= 1'b0;
      b_deb_q       <= 1'b0;
      change_mode_q <= 1'b0;
      sw_held_q     <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      stable_q      <= stable_d;
      stable_dly_q  <= stable_dly_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      settle_q      <= settle_d;
      a_pulse_q     <= a_pulse_d;
      b_deb_q       <= b_deb_d;
      change_mode_q <= change_mode_d;
      sw_held_q     <= sw_held_d;
    end
  end

  assign o_Encoder_A_Pulse     = a_pulse_q;
  assign o_Encoder_B_Debounced = b_deb_q;
  assign o_Encoder_Change_Mode = change_mode_q;
  assign o_Encoder_Switch_Held = sw_held_q;

endmodule

`default_nettype wire
